seq_dwell_monitor: RTL



---
 rtl/seq_dwell_monitor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_dwell_monitor.sv
// Watches a hold-counter value stream: flags illegal steps, measures wrap period,
// and queues one {value, dwell length} record per multi-sample dwell in an FWFT FIFO.
module seq_dwell_monitor #(
    parameter int WIDTH    = 3,
    parameter int RUN_W    = 4,
    parameter int PERIOD_W = 8,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    input  logic [WIDTH-1:0]    in_val,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [WIDTH-1:0]    ev_value,
    output logic [RUN_W-1:0]    ev_len,
    output logic                period_vld,
    output logic [PERIOD_W-1:0] period,
    output logic                seq_err,
    output logic [7:0]          drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                armed_q, armed_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_vld_q, period_vld_d;
    logic                seq_err_q, seq_err_d;
    logic [7:0]          drop_q, drop_d;
    logic [AW:0]         wr_q, wr_d;
    logic [AW:0]         rd_q, rd_d;

    logic [WIDTH-1:0]    val_mem_q [DEPTH];
    logic [RUN_W-1:0]    len_mem_q [DEPTH];

    logic [WIDTH-1:0]    prev_inc;
    logic [PERIOD_W-1:0] cnt_inc;
    logic                push, pop, full, empty, wr_en;

    assign prev_inc = prev_q + WIDTH'(1);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + PERIOD_W'(1);

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && ev_ready;
    assign wr_en = push && (!full || pop);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        armed_d      = armed_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        seq_err_d    = seq_err_q;
        push         = 1'b0;
        if (in_vld) begin
            case (state_q)
                S_INIT: begin
                    prev_d  = in_val;
                    run_d   = RUN_W'(1);
                    state_d = S_RUN;
                end
                default: begin
                    if (armed_q) begin
                        cnt_d = cnt_inc;
                    end
                    if (in_val == prev_q) begin
                        if (!(&run_q)) begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else if (in_val == prev_inc) begin
                        push   = (run_q >= RUN_W'(2));
                        prev_d = in_val;
                        run_d  = RUN_W'(1);
                        // Stepping off the top value is the wrap that delimits a period.
                        if (&prev_q) begin
                            if (armed_q) begin
                                period_d     = cnt_q;
                                period_vld_d = 1'b1;
                            end
                            armed_d = 1'b1;
                            cnt_d   = PERIOD_W'(1);
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        prev_d    = in_val;
                        run_d     = RUN_W'(1);
                        armed_d   = 1'b0;
                        cnt_d     = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        wr_d   = wr_q + (AW+1)'(wr_en);
        rd_d   = rd_q + (AW+1)'(pop);
        drop_d = drop_q;
        if (push && full && !pop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            prev_q       <= '0;
            run_q        <= '0;
            armed_q      <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            seq_err_q    <= 1'b0;
            drop_q       <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            seq_err_q    <= seq_err_d;
            drop_q       <= drop_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            val_mem_q[wr_q[AW-1:0]] <= prev_q;
            len_mem_q[wr_q[AW-1:0]] <= run_q;
        end
    end

    assign ev_valid   = !empty;
    assign ev_value   = val_mem_q[rd_q[AW-1:0]];
    assign ev_len     = len_mem_q[rd_q[AW-1:0]];
    assign period_vld = period_vld_q;
    assign period     = period_q;
    assign seq_err    = seq_err_q;
    assign drop_cnt   = drop_q;

endmodule
